// File: rtl/regfile_write_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto the single register-file write port.
// Define ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module regfile_write_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [ADDR_W-1:0]         write_reg,
   output logic [DATA_W-1:0]         write_data,
   output logic                      regwrite_con,
   output logic [2:0]                grant_id
);

   logic              grant_any;
   logic [2:0]        grant_idx;
   logic              accept;
   logic [ADDR_W-1:0] sel_reg;
   logic [DATA_W-1:0] sel_data;

   logic              regwrite_con_q, regwrite_con_d;
   logic [ADDR_W-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic [2:0]        grant_id_q, grant_id_d;

`ifdef ROUND_ROBIN_EN
   logic [2:0] rr_ptr_q, rr_ptr_d;
   logic       hi_any;
   logic [2:0] hi_idx;
`endif

   // Lowest valid index overall; with round robin, prefer the lowest valid index above rr_ptr
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
`ifdef ROUND_ROBIN_EN
      hi_any = 1'b0;
      hi_idx = '0;
`endif
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            grant_any = 1'b1;
            grant_idx = 3'(i);
         end
`ifdef ROUND_ROBIN_EN
         if (req_valid[i] && (3'(i) > rr_ptr_q)) begin
            hi_any = 1'b1;
            hi_idx = 3'(i);
         end
`endif
      end
`ifdef ROUND_ROBIN_EN
      if (hi_any) begin
         grant_idx = hi_idx;
      end
`endif
   end

   assign accept = grant_any && !stall && !reset;

   always_comb begin
      req_ready = '0;
      sel_reg   = '0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == 3'(i)) begin
            req_ready[i] = accept;
            sel_reg      = req_reg[i*ADDR_W +: ADDR_W];
            sel_data     = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Writes to $0 complete the handshake but never reach the register file
   always_comb begin
      regwrite_con_d = 1'b0;
      write_reg_d    = write_reg_q;
      write_data_d   = write_data_q;
      grant_id_d     = grant_id_q;
      if (accept) begin
         grant_id_d = grant_idx;
         if (sel_reg != '0) begin
            regwrite_con_d = 1'b1;
            write_reg_d    = sel_reg;
            write_data_d   = sel_data;
         end
      end
   end

`ifdef ROUND_ROBIN_EN
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = grant_idx;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         regwrite_con_q <= 1'b0;
         write_reg_q    <= '0;
         write_data_q   <= '0;
         grant_id_q     <= '0;
`ifdef ROUND_ROBIN_EN
         rr_ptr_q       <= 3'(NUM_REQ - 1);
`endif
      end else begin
         regwrite_con_q <= regwrite_con_d;
         write_reg_q    <= write_reg_d;
         write_data_q   <= write_data_d;
         grant_id_q     <= grant_id_d;
`ifdef ROUND_ROBIN_EN
         rr_ptr_q       <= rr_ptr_d;
`endif
      end
   end

   assign regwrite_con = regwrite_con_q;
   assign write_reg    = write_reg_q;
   assign write_data   = write_data_q;
   assign grant_id     = grant_id_q;

endmodule
